// File: rtl/canny_dual_thresh.sv
// canny_dual_thresh: derives hysteresis thresholds from the frame max and classifies gradient beats (option macro: CANNY_THR_FLOOR_EN)
module canny_dual_thresh #(
    parameter int DW = 20,
    parameter logic [7:0] HI_NUM = 8'd179,
    parameter logic [7:0] LO_NUM = 8'd77
`ifdef CANNY_THR_FLOOR_EN
    , parameter logic [DW-1:0] THR_FLOOR = DW'(16)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_end,
    input  logic [DW-1:0] max_val,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_class,
    output logic [7:0]    out_pix,
    output logic [DW-1:0] thr_hi,
    output logic [DW-1:0] thr_lo,
    output logic          calc_busy
);
    localparam int AW = DW + 8;
    typedef enum logic [1:0] {RUN, CALC, LOAD} state_t;
    state_t state, state_nx;
    logic [DW-1:0] max_q, hi_raw, lo_raw, hi_n, lo_n;
    logic [AW-1:0] acc_hi, acc_lo, max_ext;
    logic [2:0] cnt;
    logic accept;
    assign max_ext = AW'(max_q);
    assign hi_raw = DW'(acc_hi >> 8);
    assign lo_raw = DW'(acc_lo >> 8);
`ifdef CANNY_THR_FLOOR_EN
    logic [DW-1:0] hi_f, lo_f;
    assign hi_f = hi_raw < THR_FLOOR ? THR_FLOOR : hi_raw;
    assign lo_f = lo_raw < THR_FLOOR ? THR_FLOOR : lo_raw;
    assign hi_n = hi_f;
    assign lo_n = lo_f < hi_f ? lo_f : hi_f;
`else
    assign hi_n = hi_raw;
    assign lo_n = lo_raw < hi_raw ? lo_raw : hi_raw;
`endif
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign calc_busy = state != RUN;
    // state register
    always_ff @(posedge clk)
        state <= rst ? RUN : state_nx;
    // next state: a frame_end during CALC restarts the calculation
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = frame_end ? CALC : RUN;
            CALC:    state_nx = (frame_end || cnt != 3'd7) ? CALC : LOAD;
            default: state_nx = RUN;
        endcase
    end
    // serial shift-add of max*NUM, then threshold load
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            thr_hi <= '1;
            thr_lo <= '1;
        end else if (frame_end && state != LOAD) begin
            max_q  <= max_val;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc_hi <= acc_hi + (HI_NUM[cnt] ? max_ext << cnt : '0);
            acc_lo <= acc_lo + (LO_NUM[cnt] ? max_ext << cnt : '0);
            cnt    <= cnt + 3'd1;
        end else if (state == LOAD) begin
            thr_hi <= hi_n;
            thr_lo <= lo_n;
        end
    end
    // output register: classify accepted beats, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_class <= 2'b00;
            out_pix   <= 8'h00;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_class <= in_data >= thr_hi ? 2'b10 : in_data >= thr_lo ? 2'b01 : 2'b00;
            out_pix   <= in_data >= thr_hi ? 8'hFF : in_data >= thr_lo ? 8'h80 : 8'h00;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_canny_dual_thresh.sv
// tb_canny_dual_thresh: directed stimulus with a behavioural threshold/classification model
module tb_canny_dual_thresh;
    logic clk, rst, frame_end, in_valid, in_ready, out_valid, out_ready, calc_busy;
    logic [19:0] max_val, in_data, thr_hi, thr_lo;
    logic [1:0] out_class;
    logic [7:0] out_pix;
    int tests = 0, fails = 0;
    longint m_hi = 20'hFFFFF, m_lo = 20'hFFFFF, pm = 0;
    int cd = 0;
    logic [1:0] q[$];

    canny_dual_thresh dut (
        .clk(clk), .rst(rst), .frame_end(frame_end), .max_val(max_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_pix(out_pix), .thr_hi(thr_hi), .thr_lo(thr_lo), .calc_busy(calc_busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] cls(input longint d, input longint h, input longint l);
        return d >= h ? 2'b10 : d >= l ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [7:0] pix(input logic [1:0] c);
        return c == 2'b10 ? 8'hFF : c == 2'b01 ? 8'h80 : 8'h00;
    endfunction

    // model: thresholds appear 9 edges after the last accepted frame_end
    always @(posedge clk) begin
        if (rst) begin
            m_hi = 20'hFFFFF;
            m_lo = 20'hFFFFF;
            cd = 0;
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(cls(in_data, m_hi, m_lo));
            if (frame_end && cd != 1) begin
                cd = 9;
                pm = max_val;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    longint h, l;
                    h = pm * 179 / 256;
                    l = pm * 77 / 256;
`ifdef CANNY_THR_FLOOR_EN
                    if (h < 16) h = 16;
                    if (l < 16) l = 16;
`endif
                    m_hi = h;
                    m_lo = l < h ? l : h;
                end
            end
        end
    end

    // compare DUT against model every cycle
    always @(posedge clk) begin
        #1;
        chk("thr_hi", thr_hi, m_hi[19:0]);
        chk("thr_lo", thr_lo, m_lo[19:0]);
        chk("calc_busy", calc_busy, cd != 0);
        chk("in_ready", in_ready, cd == 0 && (q.size() == 0 || out_ready));
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_class", out_class, q[0]);
            chk("out_pix", out_pix, pix(q[0]));
        end
    end

    task automatic send(input logic [19:0] d);
        @(negedge clk);
        in_valid = 1;
        in_data = d;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic pulse(input logic [19:0] m);
        @(negedge clk);
        frame_end = 1;
        max_val = m;
        @(negedge clk);
        frame_end = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && calc_busy; i++) @(negedge clk);
        chk("idle_timeout", calc_busy, 0);
    endtask

    initial begin
        int busy;
        rst = 1; frame_end = 0; max_val = 0; in_valid = 0; in_data = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_thr_hi", thr_hi, 20'hFFFFF);
        chk("rst_thr_lo", thr_lo, 20'hFFFFF);
        chk("rst_busy", calc_busy, 0);
        chk("rst_valid", out_valid, 0);
        send(20'hFFFFE);
        chk("lit_fffffe", out_class, 2'b00);
        send(20'hFFFFF);
        chk("lit_fffff", out_class, 2'b10);
        pulse(20'd1000);
        busy = 0;
        for (int i = 0; i < 20 && calc_busy; i++) begin
            busy++;
            @(negedge clk);
        end
        chk("busy_cycles", busy, 9);
        chk("lit_hi_1000", thr_hi, 699);
        chk("lit_lo_1000", thr_lo, 300);
        send(20'd699); chk("lit_699", {out_class, out_pix}, {2'b10, 8'hFF});
        send(20'd698); chk("lit_698", {out_class, out_pix}, {2'b01, 8'h80});
        send(20'd300); chk("lit_300", {out_class, out_pix}, {2'b01, 8'h80});
        send(20'd299); chk("lit_299", {out_class, out_pix}, {2'b00, 8'h00});
        @(negedge clk);
        out_ready = 0;
        in_valid = 1;
        in_data = 20'd700;
        @(negedge clk);
        in_data = 20'd500;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", {out_valid, out_class, out_pix}, {1'b1, 2'b10, 8'hFF});
        end
        out_ready = 1;
        @(negedge clk);
        in_data = 20'd100;
        @(negedge clk);
        in_data = 20'd699;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        frame_end = 1;
        max_val = 20'd5000;
        in_valid = 1;
        in_data = 20'd699;
        @(negedge clk);
        frame_end = 0;
        in_valid = 0;
        chk("same_edge_old_thr", out_class, 2'b10);
        chk("same_edge_in_ready", in_ready, 0);
        repeat (4) @(negedge clk);
        pulse(20'd2000);
        wait_idle();
        chk("lit_hi_2000", thr_hi, 1398);
        chk("lit_lo_2000", thr_lo, 601);
        pulse(20'd0);
        wait_idle();
`ifdef CANNY_THR_FLOOR_EN
        chk("lit_floor_hi", thr_hi, 16);
        send(20'd15); chk("lit_floor_15", out_class, 2'b00);
        send(20'd16); chk("lit_floor_16", out_class, 2'b10);
`else
        chk("lit_zero_hi", thr_hi, 0);
        send(20'd0); chk("lit_zero_0", out_class, 2'b10);
`endif
        @(negedge clk);
        out_ready = 0;
        send(20'd5);
        pulse(20'd1000);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        chk("mid_rst_busy", calc_busy, 0);
        chk("mid_rst_thr", thr_hi, 20'hFFFFF);
        chk("mid_rst_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
